// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the video timing generator.
// Holds the default horizontal/vertical timing (pixels/lines), the derived
// totals, the counter widths and the region-decode helper used by both axes.
package video_timing_pkg;

  localparam int unsigned CNT_W = 10;  // hcount/vcount width
  localparam int unsigned DIV_W = 4;   // enough for CE_DIV up to 16

  localparam int unsigned DEF_CE_DIV = 4;

  localparam int unsigned DEF_H_ACTIVE = 256;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 24;
  localparam int unsigned DEF_H_BP     = 24;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int unsigned DEF_V_ACTIVE = 240;
  localparam int unsigned DEF_V_FP     = 4;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BP     = 15;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [CNT_W-1:0] count_t;

  typedef struct packed {
    logic blank;
    logic sync;
  } axis_flags_t;

  // Region decode for one axis. Only less-than against constants is used so
  // the comparison never needs a wider intermediate.
  function automatic axis_flags_t axis_region(count_t      c,
                                              int unsigned active,
                                              int unsigned fp,
                                              int unsigned sync_len);
    axis_flags_t f;
    count_t      act_c;
    count_t      sync_start;
    count_t      sync_end;
    act_c      = count_t'(active);
    sync_start = count_t'(active + fp);
    sync_end   = count_t'(active + fp + sync_len);
    f.blank    = !(c < act_c);
    f.sync     = !(c < sync_start) && (c < sync_end);
    return f;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Video timing bundle: pixel enable, sync/blank flags, data enable, frame
// pulse and the current pixel/line position.
//   master: driven by the timing generator
//   slave : consumed by downstream video logic
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic   ce_pix;
  logic   hs;
  logic   vs;
  logic   hb;
  logic   vb;
  logic   de;
  logic   frame_start;
  count_t hcount;
  count_t vcount;

  modport master (
    output ce_pix, hs, vs, hb, vb, de, frame_start, hcount, vcount
  );

  modport slave (
    input ce_pix, hs, vs, hb, vb, de, frame_start, hcount, vcount
  );
endinterface

// File: rtl/video_axis_counter.sv
// One timing axis (horizontal or vertical): a position counter that advances
// on adv and wraps from TOTAL-1 to 0, plus registered blank/sync flags
// decoded from the next count so flags and count change on the same edge.
// Ports:
//   clk_vid, reset_n : clock, synchronous active-low reset
//   adv              : advance the counter this edge
//   wrap             : combinational, high when this edge wraps the counter
//   count            : registered position
//   blank, sync      : registered region flags for count
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic   clk_vid,
  input  logic   reset_n,
  input  logic   adv,
  output logic   wrap,
  output count_t count,
  output logic   blank,
  output logic   sync
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
  localparam count_t      LAST  = count_t'(TOTAL - 1);

  count_t      count_q, count_d;
  axis_flags_t flags_q, flags_d;

  always_comb begin
    wrap    = adv && (count_q == LAST);
    count_d = count_q;
    if (adv) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
    flags_d = axis_region(count_d, ACTIVE, FP, SYNC);
  end

  always_ff @(posedge clk_vid) begin
    if (!reset_n) begin
      count_q <= '0;
      flags_q <= '0;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign count = count_q;
  assign blank = flags_q.blank;
  assign sync  = flags_q.sync;

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator. Divides clk_vid by CE_DIV into a one-cycle pixel
// enable, then runs horizontal and vertical position counters with
// registered sync/blank flags and a frame-start pulse.
// Ports:
//   clk_vid : video clock
//   reset_n : synchronous active-low reset; aborts the frame immediately
//   vid     : master side of the timing bundle (ce_pix, hs, vs, hb, vb, de,
//             frame_start, hcount, vcount)
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned CE_DIV   = DEF_CE_DIV,  // 2..16
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic                clk_vid,
  input  logic                reset_n,
  video_timing_gen_if.master  vid
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             ce_pix_q;
  logic             frame_start_q;
  logic             h_wrap, v_wrap;
  count_t           hcount, vcount;
  logic             hb, hs, vb, vs;

  // ce_pix is registered from the divider, so it is high in the cycle after
  // the divider sits at CE_DIV-1; the counters step on that following edge.
  always_ff @(posedge clk_vid) begin
    if (!reset_n) begin
      div_q         <= '0;
      ce_pix_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      ce_pix_q      <= (div_q == DIV_LAST);
      // Both axes wrapping on this edge means the counters land on (0,0).
      frame_start_q <= h_wrap && v_wrap;
    end
  end

  video_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk_vid (clk_vid),
    .reset_n (reset_n),
    .adv     (ce_pix_q),
    .wrap    (h_wrap),
    .count   (hcount),
    .blank   (hb),
    .sync    (hs)
  );

  // Vertical axis only moves on a line wrap, so vs/vb change at line edges.
  video_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk_vid (clk_vid),
    .reset_n (reset_n),
    .adv     (h_wrap),
    .wrap    (v_wrap),
    .count   (vcount),
    .blank   (vb),
    .sync    (vs)
  );

  assign vid.ce_pix      = ce_pix_q;
  assign vid.hs          = hs;
  assign vid.vs          = vs;
  assign vid.hb          = hb;
  assign vid.vb          = vb;
  assign vid.de          = ~hb & ~vb;
  assign vid.frame_start = frame_start_q;
  assign vid.hcount      = hcount;
  assign vid.vcount      = vcount;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Default horizontal timing and CE_DIV=4 with a
// shortened vertical frame so several frames fit in a short run.
module tb_video_timing_gen;

  localparam int unsigned D  = 4;
  localparam int unsigned HA = 256, HF = 16, HS = 24, HB = 24;
  localparam int unsigned VA = 8, VF = 2, VS = 3, VB = 3;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  typedef struct packed {
    logic       ce;
    logic       hs;
    logic       vs;
    logic       hb;
    logic       vb;
    logic       de;
    logic       fs;
    logic [9:0] hc;
    logic [9:0] vc;
  } vid_t;

  logic clk_vid = 1'b0;
  logic reset_n = 1'b0;

  video_timing_gen_if vid();

  video_timing_gen #(
    .CE_DIV   (D),
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .clk_vid (clk_vid),
    .reset_n (reset_n),
    .vid     (vid)
  );

  always #5 clk_vid = ~clk_vid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // k = number of clock edges since the last edge that sampled reset_n=0.
  int unsigned k = 0;
  bit          started = 1'b0;

  always @(posedge clk_vid) begin
    if (!reset_n) begin
      k       <= 0;
      started <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  // Expected outputs after k edges out of reset, from plain arithmetic:
  // ce after every D-th edge; pixel p = edges that saw ce high.
  function automatic vid_t model(int unsigned kk);
    vid_t        r;
    int unsigned p, hc, vc;
    p    = (kk == 0) ? 0 : (kk - 1) / D;
    hc   = p % HT;
    vc   = (p / HT) % VT;
    r.ce = (kk > 0) && (kk % D == 0);
    r.hc = 10'(hc);
    r.vc = 10'(vc);
    r.hb = (hc >= HA);
    r.hs = (hc >= HA + HF) && (hc < HA + HF + HS);
    r.vb = (vc >= VA);
    r.vs = (vc >= VA + VF) && (vc < VA + VF + VS);
    r.de = !r.hb && !r.vb;
    r.fs = (kk > 1) && ((kk - 1) % D == 0) && (p > 0) && (p % (HT * VT) == 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Per-cycle comparison against the model plus the flag/counter rules.
  always @(negedge clk_vid) begin
    vid_t e, a;
    if (started) begin
      e    = model(k);
      a.ce = vid.ce_pix;
      a.hs = vid.hs;
      a.vs = vid.vs;
      a.hb = vid.hb;
      a.vb = vid.vb;
      a.de = vid.de;
      a.fs = vid.frame_start;
      a.hc = vid.hcount;
      a.vc = vid.vcount;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model k=%0d got %h want %h", k, a, e);
      end
      checks++;
      if ((vid.hb !== (vid.hcount >= 10'(HA))) ||
          (vid.hs !== ((vid.hcount >= 10'(HA + HF)) && (vid.hcount < 10'(HA + HF + HS)))) ||
          (vid.vb !== (vid.vcount >= 10'(VA))) ||
          (vid.vs !== ((vid.vcount >= 10'(VA + VF)) && (vid.vcount < 10'(VA + VF + VS)))) ||
          (vid.de !== (!vid.hb && !vid.vb))) begin
        errors++;
        $display("FAIL align k=%0d hc=%0d vc=%0d got hb%b hs%b vb%b vs%b de%b", k,
                 vid.hcount, vid.vcount, vid.hb, vid.hs, vid.vb, vid.vs, vid.de);
      end
    end
  end

  // Period/length monitor: index 0 hs, 1 hb, 2 vs, 3 vb, 4 frame_start.
  bit          measure_en = 1'b0;
  logic [4:0]  prev = '0;
  int unsigned cyc = 0;
  int unsigned rise_t[5];
  int unsigned per[5];
  int unsigned len[5];

  always @(negedge clk_vid) begin
    logic [4:0] sig;
    cyc++;
    sig = {vid.frame_start, vid.vb, vid.vs, vid.hb, vid.hs};
    if (measure_en) begin
      for (int i = 0; i < 5; i++) begin
        if (sig[i] && !prev[i]) begin
          if (rise_t[i] != 0) per[i] = cyc - rise_t[i];
          rise_t[i] = cyc;
        end
        if (!sig[i] && prev[i] && rise_t[i] != 0) len[i] = cyc - rise_t[i];
      end
    end
    prev = sig;
  end

  initial begin
    vid_t        m;
    int unsigned n;
    bit          found;

    for (int i = 0; i < 5; i++) begin
      rise_t[i] = 0;
      per[i]    = 0;
      len[i]    = 0;
    end

    // Pin the model with hand-derived points.
    m = model(3);
    check("mdl_ce_k3", {31'd0, m.ce}, 32'd0);
    m = model(4);
    check("mdl_ce_k4", {31'd0, m.ce}, 32'd1);
    m = model(5);
    check("mdl_hc_k5", {22'd0, m.hc}, 32'd1);
    m = model(272 * 4 + 1);
    check("mdl_hs_on", {31'd0, m.hs}, 32'd1);
    m = model(272 * 4);
    check("mdl_hs_off", {31'd0, m.hs}, 32'd0);
    m = model(20481);
    check("mdl_fs", {31'd0, m.fs}, 32'd1);

    // Reset held for 4 cycles.
    repeat (4) @(negedge clk_vid);
    check("rst_flags", {26'd0, vid.ce_pix, vid.hs, vid.vs, vid.hb, vid.vb, vid.frame_start},
          32'd0);
    check("rst_de", {31'd0, vid.de}, 32'd1);
    check("rst_cnt", {12'd0, vid.hcount, vid.vcount}, 32'd0);

    // Release and locate the first ce_pix.
    reset_n    = 1'b1;
    measure_en = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_vid);
      n++;
      if (vid.ce_pix) break;
    end
    check("first_ce_edge", n, 32'd4);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_vid);
      n++;
      if (vid.ce_pix) break;
    end
    check("ce_period", n, 32'd4);

    // Two full frames for line/frame measurements.
    repeat (41500) @(negedge clk_vid);
    measure_en = 1'b0;
    check("hs_period", per[0], 32'd1280);
    check("hs_len", len[0], 32'd96);
    check("hb_len", len[1], 32'd256);
    check("hb_period", per[1], 32'd1280);
    check("vs_len", len[2], 32'd3840);
    check("vs_period", per[2], 32'd20480);
    check("vb_len", len[3], 32'd10240);
    check("fs_period", per[4], 32'd20480);
    check("fs_len", len[4], 32'd1);

    // Mid-frame reset while vs and vb are high.
    found = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk_vid);
      m = model(k);
      if (m.hc == 10'd50 && m.vc == 10'd10) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_found", {31'd0, found}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk_vid);
    check("midrst_zero", {5'd0, vid.ce_pix, vid.hs, vid.vs, vid.hb, vid.vb, vid.frame_start,
          vid.hcount, vid.vcount}, 32'd0);
    check("midrst_de", {31'd0, vid.de}, 32'd1);
    @(negedge clk_vid);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_vid);
      n++;
      if (vid.ce_pix) break;
    end
    check("restart_ce_edge", n, 32'd4);

    // Random run lengths with random reset pulses.
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(50, 2000)) @(negedge clk_vid);
      reset_n = 1'b0;
      repeat ($urandom_range(1, 5)) @(negedge clk_vid);
      reset_n = 1'b1;
    end
    repeat (500) @(negedge clk_vid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter CE_DIV, default 4: clk_vid cycles per pixel; legal values 2..16.
REQ-002 SHALL have parameters H_ACTIVE=256, H_FP=16, H_SYNC=24, H_BP=24 (pixels) and V_ACTIVE=240, V_FP=4, V_SYNC=3, V_BP=15 (lines).
REQ-003 SHALL define H_TOTAL as the sum of the four H parameters (320) and V_TOTAL as the sum of the four V parameters (262).
REQ-004 SHALL have port clk_vid  input  1  video clock; one clock only.
REQ-005 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port ce_pix  output  1  one-cycle pixel enable.
REQ-007 SHALL have port hs  output  1  horizontal sync, active-high.
REQ-008 SHALL have port vs  output  1  vertical sync, active-high.
REQ-009 SHALL have port hb  output  1  horizontal blank, active-high.
REQ-010 SHALL have port vb  output  1  vertical blank, active-high.
REQ-011 SHALL have port hcount  output  10  current pixel x position.
REQ-012 SHALL have port vcount  output  10  current line y position.
REQ-013 SHALL have port de  output  1  data enable, equal to ~hb & ~vb.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse at the first pixel of each frame.

Function
REQ-015 Divider SHALL count 0..CE_DIV-1; ce_pix SHALL be registered and high for exactly one clk_vid cycle when the divider is at CE_DIV-1.
REQ-016 hcount SHALL advance on every clk_vid edge where ce_pix=1, wrapping from H_TOTAL-1 to 0.
REQ-017 vcount SHALL advance only on an hcount wrap, wrapping from V_TOTAL-1 to 0.
REQ-018 hs, vs, hb, vb, de and frame_start SHALL be registered, computed from the next counter values, and update on the same edge as hcount/vcount, so no skew exists between counters and flags.
REQ-019 hb SHALL be 1 exactly for hcount>=H_ACTIVE.
REQ-020 hs SHALL be 1 exactly for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
REQ-021 vb SHALL be 1 exactly for vcount>=V_ACTIVE.
REQ-022 vs SHALL be 1 exactly for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC.
REQ-023 vs and vb SHALL change only at an hcount wrap (line boundary).
REQ-024 frame_start SHALL be high for exactly the single clk_vid cycle following the ce_pix edge that sets hcount=0 and vcount=0.
REQ-025 Counter arithmetic SHALL be 10-bit unsigned; comparisons SHALL use equality or less-than against constants, with no overflow for legal parameters.

Reset
REQ-026 While reset_n=0 at a clk_vid edge: divider, hcount and vcount SHALL be 0, and ce_pix, hs, vs, hb, vb and frame_start SHALL be 0.
REQ-027 de SHALL be 1 during reset, since it follows ~hb & ~vb.
REQ-028 After release, the first ce_pix SHALL occur CE_DIV cycles after the first edge with reset_n=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with no partial sync pulse extension.

Structure
REQ-030 Default timing constants and the H/V totals SHALL live in shared package video_timing_pkg.
REQ-031 One sub-module, video_axis_counter, SHALL implement the per-axis counter, wrap and region flags, and SHALL be instantiated once for H and once for V.

Verification
REQ-032 Reset release: 4 clk_vid cycles with reset_n=0 -> outputs hold their reset values; first ce_pix at cycle 4 after release; ce_pix period 4.
REQ-033 Line timing: consecutive hs rising edges 1280 clk_vid cycles apart; hs high 96 cycles; hb high 256 cycles per line.
REQ-034 Frame timing: vs high 3 lines (3840 cycles); vb high 22 lines; frame_start period 335360 cycles.
REQ-035 Alignment: at every cycle, check hb, hs, vb, vs and de against the hcount/vcount rules of REQ-019 to REQ-022 and REQ-013; any mismatch is a failure.
REQ-036 Mid-frame reset: assert reset_n=0 at vcount=100, hcount=50 -> next cycle all flags and counters are 0; timing restarts cleanly.
REQ-037 Loopback: drive a scandoubler instance with this block's outputs -> its hs_out period is 640 cycles.
